// File: rtl/sram_pkg.sv
// Shared widths, slot numbering and owner encoding for the SRAM slot arbiter.
package sram_pkg;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  localparam logic [1:0] SLOT_VID = 2'd0;
  localparam logic [1:0] SLOT_CPU = 2'd1;
  localparam logic [1:0] SLOT_DMA = 2'd2;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_VID,
    OWN_CPU,
    OWN_DMA
  } owner_e;

endpackage

// File: rtl/sram_slot_gen.sv
// Three-slot rotation counter; slot_sync forces slot 0 at the next edge.
module sram_slot_gen
  import sram_pkg::*;
(
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       slot_sync,
  output logic [1:0] slot,
  output logic [1:0] slot_next
);

  logic [1:0] slot_q, slot_d;

  always_comb begin
    slot_d = (slot_q == SLOT_DMA) ? SLOT_VID : slot_q + 2'd1;
    if (slot_sync) slot_d = SLOT_VID;
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) slot_q <= SLOT_VID;
    else        slot_q <= slot_d;
  end

  assign slot      = slot_q;
  assign slot_next = slot_d;

endmodule

// File: rtl/sram_slot_arbiter.sv
// Slot-based owner selection, registered SRAM strobes and tag-routed read capture.
module sram_slot_arbiter #(
  parameter int unsigned AW = sram_pkg::AW,
  parameter int unsigned DW = sram_pkg::DW
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          slot_sync,
  output logic [1:0]    slot,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rdy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [1:0]    dma_be,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          ce_n,
  output logic          oe_n,
  output logic          we_n,
  output logic          lb_n,
  output logic          ub_n
);

  import sram_pkg::*;

  logic [1:0] slot_next;

  sram_slot_gen u_slot_gen (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .slot_sync (slot_sync),
    .slot      (slot),
    .slot_next (slot_next)
  );

  owner_e        owner;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dq_q, dq_d;
  logic          dq_oe_q, dq_oe_d;
  logic          ce_q, ce_d, oe_q, oe_d, we_q, we_d, lb_q, lb_d, ub_q, ub_d;
  logic          ack_q, ack_d;
  logic          served_q, served_d;
  // Tag travels with the access so capture never depends on the current slot.
  owner_e        tag_q, tag_d;
  logic          rd_q, rd_d;
  logic          lane_q, lane_d;

  always_comb begin
    owner = OWN_IDLE;
    case (slot_next)
      SLOT_VID: begin
        if (vid_req)      owner = OWN_VID;
        else if (dma_req) owner = OWN_DMA;
      end
      SLOT_CPU: begin
        if (cpu_req && !served_q) owner = OWN_CPU;
        else if (dma_req)         owner = OWN_DMA;
      end
      default: begin
        if (dma_req) owner = OWN_DMA;
      end
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    dq_d     = dq_q;
    dq_oe_d  = 1'b0;
    ce_d     = 1'b1;
    oe_d     = 1'b1;
    we_d     = 1'b1;
    lb_d     = 1'b1;
    ub_d     = 1'b1;
    ack_d    = 1'b0;
    tag_d    = OWN_IDLE;
    rd_d     = 1'b0;
    lane_d   = 1'b0;
    served_d = served_q;
    if (!cpu_req) served_d = 1'b0;

    unique case (owner)
      OWN_VID: begin
        addr_d = vid_addr;
        ce_d   = 1'b0;
        oe_d   = 1'b0;
        lb_d   = 1'b0;
        ub_d   = 1'b0;
        tag_d  = OWN_VID;
        rd_d   = 1'b1;
      end
      OWN_CPU: begin
        served_d = 1'b1;
        addr_d   = cpu_addr[AW:1];
        ce_d     = 1'b0;
        lb_d     = cpu_addr[0];
        ub_d     = !cpu_addr[0];
        tag_d    = OWN_CPU;
        rd_d     = !cpu_wr;
        lane_d   = cpu_addr[0];
        if (cpu_wr) begin
          we_d    = 1'b0;
          dq_oe_d = 1'b1;
          dq_d    = {cpu_wdata, cpu_wdata};
        end else begin
          oe_d    = 1'b0;
        end
      end
      OWN_DMA: begin
        ack_d = 1'b1;
        // No lanes enabled: burn the slot without touching the SRAM.
        if (dma_be != 2'b00) begin
          addr_d = dma_addr;
          ce_d   = 1'b0;
          lb_d   = !dma_be[0];
          ub_d   = !dma_be[1];
          tag_d  = OWN_DMA;
          rd_d   = !dma_wr;
          if (dma_wr) begin
            we_d    = 1'b0;
            dq_oe_d = 1'b1;
            dq_d    = dma_wdata;
          end else begin
            oe_d    = 1'b0;
          end
        end
      end
      OWN_IDLE: ;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_q     <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      ack_q    <= 1'b0;
      served_q <= 1'b0;
      tag_q    <= OWN_IDLE;
      rd_q     <= 1'b0;
      lane_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      dq_q     <= dq_d;
      dq_oe_q  <= dq_oe_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      ack_q    <= ack_d;
      served_q <= served_d;
      tag_q    <= tag_d;
      rd_q     <= rd_d;
      lane_q   <= lane_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      cpu_rdata  <= '0;
      cpu_rdy    <= 1'b0;
      vid_rdata  <= '0;
      vid_valid  <= 1'b0;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rdy    <= 1'b0;
      vid_valid  <= 1'b0;
      dma_rvalid <= 1'b0;
      unique case (tag_q)
        OWN_VID: begin
          vid_rdata <= sram_dq_i;
          vid_valid <= 1'b1;
        end
        OWN_CPU: begin
          cpu_rdy <= 1'b1;
          if (rd_q) cpu_rdata <= lane_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
        end
        OWN_DMA: begin
          if (rd_q) begin
            dma_rdata  <= sram_dq_i;
            dma_rvalid <= 1'b1;
          end
        end
        OWN_IDLE: ;
      endcase
    end
  end

  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dq_oe_q;
  assign ce_n       = ce_q;
  assign oe_n       = oe_q;
  assign we_n       = we_q;
  assign lb_n       = lb_q;
  assign ub_n       = ub_q;
  assign dma_ack    = ack_q;

endmodule

// File: doc/sram_slot_arbiter.md
Name: sram_slot_arbiter

Overview:
- Time-slot arbiter and sequencer for the shared 16-bit asynchronous SRAM.
- Runs a 3-slot rotation on mclk (slot 0 video, slot 1 CPU, slot 2 DMA). Unused video and CPU slots are donated to DMA.
- Drives all SRAM strobes from registers and captures read data back to the owning requester.
- Sits between the Z80 bus interface, video fetcher and DMA engine on one side and the SRAM pins on the other.

Parameters:
AW, 18, SRAM word-address width
DW, 16, SRAM data width (two byte lanes)

Ports:
mclk  in  1  system clock (90 MHz); the only clock
rst_n  in  1  synchronous active-low reset, sampled on posedge mclk
slot_sync  in  1  one-mclk pulse aligning the rotation; forces slot 0 at the next edge
slot  out  2  current slot index (0, 1, 2)
cpu_req  in  1  CPU access request, level, held for the whole bus cycle
cpu_wr  in  1  1 = write, 0 = read
cpu_addr  in  AW+1  byte address; bit 0 selects the byte lane
cpu_wdata  in  8  CPU write byte
cpu_rdata  out  8  CPU read byte, registered
cpu_rdy  out  1  one-cycle pulse: CPU access complete
vid_req  in  1  video fetch wanted this rotation, level
vid_addr  in  AW  video word address
vid_rdata  out  DW  fetched video word
vid_valid  out  1  one-cycle pulse: vid_rdata updated
dma_req  in  1  DMA request; hold until dma_ack
dma_wr  in  1  1 = write
dma_addr  in  AW  DMA word address
dma_wdata  in  DW  DMA write word
dma_be  in  2  byte enables {ub, lb}, active high
dma_ack  out  1  one-cycle pulse: request accepted and issued
dma_rdata  out  DW  DMA read word
dma_rvalid  out  1  one-cycle pulse: dma_rdata updated
sram_addr  out  AW  SRAM address
sram_dq_o  out  DW  SRAM write data
sram_dq_oe  out  1  data bus drive enable
sram_dq_i  in  DW  SRAM read data
ce_n, oe_n, we_n, lb_n, ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (rst_n low at an edge):
  - slot=0; all SRAM strobes 1; sram_addr=0; sram_dq_o=0; sram_dq_oe=0.
  - All rdata registers 0; all valid, rdy and ack pulses 0; cpu_served=0.
  - Any access in flight is dropped and no completion pulse is produced.
- Rotation: slot advances 0→1→2→0 each mclk. slot_sync=1 loads 0 regardless of the current slot, and is idempotent when the next slot is already 0.
- Issue: at the edge entering slot s, the owner for s is decided and the SRAM outputs are registered. They are held for exactly one mclk.
- Slot 0: video if vid_req=1, otherwise DMA if dma_req=1, otherwise idle.
- Slot 1: CPU if cpu_req=1 and cpu_served=0, otherwise DMA if dma_req=1, otherwise idle.
- Slot 2: DMA if dma_req=1, otherwise idle.
- Idle slot: ce_n=oe_n=we_n=lb_n=ub_n=1, sram_dq_oe=0, sram_addr unchanged.
- Read issue: ce_n=0, oe_n=0, we_n=1, sram_dq_oe=0.
- Write issue: ce_n=0, oe_n=1, we_n=0, sram_dq_oe=1.
- Byte lanes:
  - Video: both lanes enabled.
  - CPU: sram_addr=cpu_addr[AW:1], lb_n=cpu_addr[0], ub_n=!cpu_addr[0]. Write data is cpu_wdata replicated to both lanes.
  - DMA: lb_n=!dma_be[0], ub_n=!dma_be[1]. dma_be=00 is issued as a no-op slot with ce_n=1 and still acked.
- Read capture: sram_dq_i is sampled at the edge ending the access cycle. The matching rdata register and valid/rdy pulse are asserted in the following cycle. Read latency is 2 edges from issue.
- CPU read data: cpu_rdata = selected byte (low byte when cpu_addr[0]=0).
- CPU write completion: cpu_rdy pulses in the cycle after the write cycle, the same timing as a read.
- cpu_served:
  - Set on CPU issue; cleared when cpu_req=0.
  - Exactly one SRAM access per CPU request assertion, however long cpu_req is held.
- dma_ack: pulses in the issue cycle. DMA may change address and data the cycle after the ack. A new dma_req is eligible at the very next slot, so back-to-back DMA can fill slot 2 and donated slots.
- slot_sync mid-rotation: the access already issued completes and delivers its data normally; only future slot ownership shifts.
- A tag of the owner per issued access is pipelined alongside. Captured data is routed by tag, never by the current slot.

Decomposition:
- Shared package sram_pkg holds:
  - Slot constants SLOT_VID=0, SLOT_CPU=1, SLOT_DMA=2.
  - Owner enum {OWN_IDLE, OWN_VID, OWN_CPU, OWN_DMA}.
  - Width parameters AW and DW.
- One sub-module, sram_slot_gen: slot counter with the slot_sync override and reset.
- Issue mux, tag pipeline and capture registers stay in the top level.

Test Plan:
- Reset, then free-run with no requests → slot 0,1,2,0…; all strobes stay 1; no pulses.
- vid_req=1, vid_addr=0x12345, sram_dq_i=0xBEEF → at slot 0: sram_addr=0x12345, ce_n=oe_n=0; vid_valid pulses 2 edges later with vid_rdata=0xBEEF; repeats every 3 cycles.
- CPU read cpu_addr=0x00003 held 9 cycles, sram_dq_i=0xA55A → exactly one access, at slot 1 with sram_addr=0x00001, ub_n=0, lb_n=1; cpu_rdata=0xA5; single cpu_rdy pulse.
- cpu_req=0, vid_req=0, dma_req held with writes 0x1111/0x2222, be=11 → DMA issued in slots 0, 1 and 2 consecutively; we_n=0, dq_oe=1; one dma_ack per issue.
- Video read issued at slot 0, then slot_sync at the next edge → vid_valid still delivered with the correct data; slot reads 0 again after the sync.
- rst_n low in the cycle after a DMA read issue → no dma_rvalid; all outputs at reset values on the next edge.
